alu_mc: RTL and testbench

//  Parametrised multicycle ALU; next generation of the 32-bit single-cycle ALU wrapper.

---
 rtl/alu_mc.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc - parametrised multicycle ALU for the EX stage.
//
// Logic, arithmetic, compare and shift operations complete in one cycle.
// Signed MUL and DIV run iteratively (one bit per cycle) and finish in
// exactly W+1 cycles from the accepting edge. Results and flags are
// registered and hold until the next completion or reset.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          request; sampled only while busy == 0
//   FS[4:0]        function select
//   S, T [W-1:0]   operands
//   SHAMT[SW-1:0]  shift amount
//   busy           iterative operation in progress
//   done           one-cycle pulse: Y_hi/Y_lo/flags valid
//   Y_hi [W-1:0]   product high / remainder (0 for single-cycle ops)
//   Y_lo [W-1:0]   product low / quotient / ALU result
//   C, V, N, Z     carry, overflow, negative, zero flags
//   DZ             divide-by-zero flag
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [4:0]    FS,
  input  logic [W-1:0]  S,
  input  logic [W-1:0]  T,
  input  logic [SW-1:0] SHAMT,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  Y_hi,
  output logic [W-1:0]  Y_lo,
  output logic          C,
  output logic          V,
  output logic          N,
  output logic          Z,
  output logic          DZ
);

  localparam logic [4:0] FS_ADD  = 5'h02;
  localparam logic [4:0] FS_ADDU = 5'h03;
  localparam logic [4:0] FS_SUB  = 5'h04;
  localparam logic [4:0] FS_SUBU = 5'h05;
  localparam logic [4:0] FS_SLT  = 5'h06;
  localparam logic [4:0] FS_SLTU = 5'h07;
  localparam logic [4:0] FS_AND  = 5'h08;
  localparam logic [4:0] FS_OR   = 5'h09;
  localparam logic [4:0] FS_XOR  = 5'h0A;
  localparam logic [4:0] FS_NOR  = 5'h0B;
  localparam logic [4:0] FS_SRL  = 5'h0C;
  localparam logic [4:0] FS_SRA  = 5'h0D;
  localparam logic [4:0] FS_SLL  = 5'h0E;
  localparam logic [4:0] FS_MUL  = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] cnt;
  logic          op_div;
  logic [W-1:0]  s_q, t_q;
  logic [W-1:0]  acc_hi, acc_lo, mag_t;
  logic [W-1:0]  abs_s, abs_t;

  assign busy  = (state != IDLE);
  assign abs_s = S[W-1] ? -S : S;
  assign abs_t = T[W-1] ? -T : T;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (FS == FS_MUL)      state_nxt = MUL;
          else if (FS == FS_DIV) state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt == SW'(W - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Single-cycle ALU, evaluated on the live inputs at the accepting edge
  // -------------------------------------------------------------------------
  logic [W-1:0] alu_res;
  logic         alu_c, alu_v;
  logic [W:0]   sum_w, diff_w;
  // Shifts are done one bit wider so the extra bit catches the last bit
  // shifted out; with SHAMT==0 that bit is naturally 0.
  logic [W:0]   sll_w, srl_w, sra_w;
  logic         lt_s, lt_u;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = {1'b0, S} + {1'b0, T};
    diff_w  = {1'b0, S} + {1'b0, ~T} + (W + 1)'(1);
    sll_w   = {1'b0, T} << SHAMT;
    srl_w   = {T, 1'b0} >> SHAMT;
    sra_w   = $signed({T, 1'b0}) >>> SHAMT;
    lt_s    = $signed(S) < $signed(T);
    lt_u    = S < T;
    case (FS)
      FS_ADD: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (S[W-1] == T[W-1]) && (sum_w[W-1] != S[W-1]);
      end
      FS_ADDU: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
      end
      FS_SUB: begin
        alu_res = diff_w[W-1:0];
        alu_c   = diff_w[W];
        alu_v   = (S[W-1] != T[W-1]) && (diff_w[W-1] != S[W-1]);
      end
      FS_SUBU: begin
        alu_res = diff_w[W-1:0];
        alu_c   = diff_w[W];
      end
      FS_SLT:  alu_res = {{(W-1){1'b0}}, lt_s};
      FS_SLTU: alu_res = {{(W-1){1'b0}}, lt_u};
      FS_AND:  alu_res = S & T;
      FS_OR:   alu_res = S | T;
      FS_XOR:  alu_res = S ^ T;
      FS_NOR:  alu_res = ~(S | T);
      FS_SRL: begin
        alu_res = srl_w[W:1];
        alu_c   = srl_w[0];
      end
      FS_SRA: begin
        alu_res = sra_w[W:1];
        alu_c   = sra_w[0];
      end
      FS_SLL: begin
        alu_res = sll_w[W-1:0];
        alu_c   = sll_w[W];
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Iteration datapath. acc_hi:acc_lo is shared: product accumulator with the
  // multiplier shifting out of acc_lo, or remainder:quotient for division.
  // -------------------------------------------------------------------------
  logic [W:0]   mul_sum, div_shift, div_diff;
  logic [W-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
  logic         div_ge;

  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_t} : '0);
    mul_hi_nxt = mul_sum[W:1];
    mul_lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
    div_shift  = {acc_hi, acc_lo[W-1]};
    div_diff   = div_shift - {1'b0, mag_t};
    div_ge     = ~div_diff[W];
    div_hi_nxt = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    div_lo_nxt = {acc_lo[W-2:0], div_ge};
  end

  // -------------------------------------------------------------------------
  // Sign correction and flags for the FIX cycle
  // -------------------------------------------------------------------------
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   fix_hi, fix_lo;
  logic           fix_neg, fix_v, fix_n, fix_z, fix_dz, div_ovf;

  always_comb begin
    fix_neg = s_q[W-1] ^ t_q[W-1];
    prod    = {acc_hi, acc_lo};
    prod_s  = fix_neg ? -prod : prod;
    div_ovf = (s_q == {1'b1, {(W-1){1'b0}}}) && (t_q == '1);
    fix_hi  = '0;
    fix_lo  = '0;
    fix_v   = 1'b0;
    fix_dz  = 1'b0;
    if (!op_div) begin
      fix_hi = prod_s[2*W-1:W];
      fix_lo = prod_s[W-1:0];
    end else if (t_q == '0) begin
      fix_hi = s_q;
      fix_lo = '1;
      fix_dz = 1'b1;
    end else begin
      // Most-negative / -1 needs no special path: the unsigned quotient
      // magnitude 2^(W-1) already reads as -2^(W-1) and is not negated.
      fix_lo = fix_neg  ? -acc_lo : acc_lo;
      fix_hi = s_q[W-1] ? -acc_hi : acc_hi;
      fix_v  = div_ovf;
    end
    fix_n = op_div ? fix_lo[W-1] : fix_hi[W-1];
    fix_z = ~|{fix_hi, fix_lo};
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      s_q    <= '0;
      t_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_t  <= '0;
      done   <= 1'b0;
      Y_hi   <= '0;
      Y_lo   <= '0;
      C      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
      DZ     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (FS == FS_MUL || FS == FS_DIV) begin
              s_q    <= S;
              t_q    <= T;
              op_div <= (FS == FS_DIV);
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= abs_s;
              mag_t  <= abs_t;
            end else begin
              Y_hi <= '0;
              Y_lo <= alu_res;
              C    <= alu_c;
              V    <= alu_v;
              N    <= alu_res[W-1];
              Z    <= ~|alu_res;
              DZ   <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          cnt    <= cnt + SW'(1);
        end
        DIV: begin
          acc_hi <= div_hi_nxt;
          acc_lo <= div_lo_nxt;
          cnt    <= cnt + SW'(1);
        end
        FIX: begin
          Y_hi <= fix_hi;
          Y_lo <= fix_lo;
          C    <= 1'b0;
          V    <= fix_v;
          N    <= fix_n;
          Z    <= fix_z;
          DZ   <= fix_dz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc - directed self-checking bench for alu_mc (W=32 and W=16).
// Inputs are driven on the falling edge and outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start;
  logic [4:0]  fs;
  logic [31:0] s, t;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] y_hi, y_lo;
  logic        c, v, n, z, dz;

  logic        start16;
  logic [4:0]  fs16;
  logic [15:0] s16, t16;
  logic [3:0]  sh16;
  logic        busy16, done16;
  logic [15:0] yh16, yl16;
  logic        c16, v16, n16, z16, dz16;

  alu_mc #(.W(32), .SW(5)) u32 (
    .clk(clk), .reset(reset), .start(start), .FS(fs), .S(s), .T(t),
    .SHAMT(shamt), .busy(busy), .done(done), .Y_hi(y_hi), .Y_lo(y_lo),
    .C(c), .V(v), .N(n), .Z(z), .DZ(dz)
  );

  alu_mc #(.W(16), .SW(4)) u16 (
    .clk(clk), .reset(reset), .start(start16), .FS(fs16), .S(s16), .T(t16),
    .SHAMT(sh16), .busy(busy16), .done(done16), .Y_hi(yh16), .Y_lo(yl16),
    .C(c16), .V(v16), .N(n16), .Z(z16), .DZ(dz16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current falling edge, scramble the operand
  // inputs after the accepting edge, then wait (bounded) for done.
  // lat counts rising edges after the accepting edge until done is seen.
  task automatic op32(input string tag, input logic [4:0] f, input logic [31:0] a, b,
                      input logic [4:0] sh, input int exp_lat,
                      input logic [31:0] eh, el, input logic [4:0] ef);
    int   lat, drops;
    logic bn;
    start = 1'b1; fs = f; s = a; t = b; shamt = sh;
    @(negedge clk);
    start = 1'b0; fs = 5'h02; s = $urandom; t = $urandom; shamt = 5'($urandom);
    bn = busy; lat = 0; drops = 0;
    while (!done && lat < 200) begin
      if (!busy) drops++;
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"},   64'(lat), 64'(exp_lat));
    check({tag, "/busy"},  64'(bn), 64'(exp_lat != 0));
    check({tag, "/drop"},  64'(drops), 64'd0);
    check({tag, "/y"},     {y_hi, y_lo}, {eh, el});
    check({tag, "/flags"}, 64'({c, v, n, z, dz}), 64'(ef));
  endtask

  task automatic op16(input string tag, input logic [4:0] f, input logic [15:0] a, b,
                      input logic [15:0] eh, el, input logic [4:0] ef);
    int lat;
    start16 = 1'b1; fs16 = f; s16 = a; t16 = b; sh16 = '0;
    @(negedge clk);
    start16 = 1'b0; s16 = 16'($urandom); t16 = 16'($urandom);
    lat = 0;
    while (!done16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"},   64'(lat), 64'd17);
    check({tag, "/y"},     64'({yh16, yl16}), 64'({eh, el}));
    check({tag, "/flags"}, 64'({c16, v16, n16, z16, dz16}), 64'(ef));
  endtask

  // Reference arithmetic for the W=16 instance built on the language's own
  // signed operators.
  logic signed [31:0] ea, eb, ep;
  logic signed [15:0] qa, qb, qq, qr;
  logic [15:0]        ra, rb, mh, ml, dh, dl;
  logic [4:0]         mf, df;
  int                 dones, done_at, busy_seen;

  initial begin
    reset = 1'b1;
    start = 1'b0; fs = '0; s = '0; t = '0; shamt = '0;
    start16 = 1'b0; fs16 = '0; s16 = '0; t16 = '0; sh16 = '0;
    repeat (2) @(negedge clk);
    check("rst/y",   {y_hi, y_lo}, 64'd0);
    check("rst/ctl", 64'({busy, done, c, v, n, z, dz}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst/idle", 64'({busy, done, busy16, done16}), 64'd0);

    // Flags order: {C, V, N, Z, DZ}
    op32("add_ovf", 5'h02, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 32'h0, 32'h80000000, 5'b01100);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("hold",       {y_hi, y_lo}, {32'h0, 32'h80000000});
    op32("sub_zero",  5'h04, 32'h5,        32'h5,        5'd0, 0, 32'h0, 32'h0,        5'b10010);
    op32("sub_ovf",   5'h04, 32'h80000000, 32'h1,        5'd0, 0, 32'h0, 32'h7FFFFFFF, 5'b11000);
    op32("subu",      5'h05, 32'h0,        32'h1,        5'd0, 0, 32'h0, 32'hFFFFFFFF, 5'b00100);
    op32("addu_wrap", 5'h03, 32'hFFFFFFFF, 32'h1,        5'd0, 0, 32'h0, 32'h0,        5'b10010);
    op32("slt",       5'h06, 32'hFFFFFFFF, 32'h1,        5'd0, 0, 32'h0, 32'h1,        5'b00000);
    op32("sltu",      5'h07, 32'hFFFFFFFF, 32'h1,        5'd0, 0, 32'h0, 32'h0,        5'b00010);
    op32("and",       5'h08, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0, 32'h0, 32'hF000F000, 5'b00100);
    op32("or",        5'h09, 32'h0F000000, 32'h000000F0, 5'd0, 0, 32'h0, 32'h0F0000F0, 5'b00000);
    op32("xor",       5'h0A, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0, 0, 32'h0, 32'h55555555, 5'b00000);
    op32("nor",       5'h0B, 32'h0,        32'h0,        5'd0, 0, 32'h0, 32'hFFFFFFFF, 5'b00100);
    op32("srl",       5'h0C, 32'h0,        32'h00000003, 5'd1, 0, 32'h0, 32'h00000001, 5'b10000);
    op32("sra1",      5'h0D, 32'h0,        32'h80000001, 5'd1, 0, 32'h0, 32'hC0000000, 5'b10100);
    op32("sll0",      5'h0E, 32'h0,        32'h12345678, 5'd0, 0, 32'h0, 32'h12345678, 5'b00000);
    op32("sll4",      5'h0E, 32'h0,        32'hF0000001, 5'd4, 0, 32'h0, 32'h00000010, 5'b10000);
    op32("sra31",     5'h0D, 32'h0,        32'h80000000, 5'd31, 0, 32'h0, 32'hFFFFFFFF, 5'b00100);
    op32("badfs",     5'h01, 32'h5,        32'h7,        5'd0, 0, 32'h0, 32'h0,        5'b00010);

    op32("mul_m2x3",  5'h1E, 32'hFFFFFFFE, 32'h3,        5'd0, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 5'b00100);
    op32("mul_min2",  5'h1E, 32'h80000000, 32'h80000000, 5'd0, 33, 32'h40000000, 32'h0,        5'b00000);
    op32("mul_zero",  5'h1E, 32'h0,        32'h12345,    5'd0, 33, 32'h0,        32'h0,        5'b00010);
    op32("mul_7xm5",  5'h1E, 32'h7,        32'hFFFFFFFB, 5'd0, 33, 32'hFFFFFFFF, 32'hFFFFFFDD, 5'b00100);
    op32("b2b_add",   5'h02, 32'h2,        32'h3,        5'd0, 0,  32'h0,        32'h5,        5'b00000);
    op32("div_m7d2",  5'h1F, 32'hFFFFFFF9, 32'h2,        5'd0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 5'b00100);
    op32("div_7dm2",  5'h1F, 32'h7,        32'hFFFFFFFE, 5'd0, 33, 32'h1,        32'hFFFFFFFD, 5'b00100);
    op32("div_zero",  5'h1F, 32'h12345678, 32'h0,        5'd0, 33, 32'h12345678, 32'hFFFFFFFF, 5'b00101);
    op32("div_ovf",   5'h1F, 32'h80000000, 32'hFFFFFFFF, 5'd0, 33, 32'h0,        32'h80000000, 5'b01100);
    op32("div_100",   5'h1F, 32'd100,      32'd10,       5'd0, 33, 32'h0,        32'd10,       5'b00000);

    // start pulses mid-MUL and in the FIX cycle must both be ignored
    start = 1'b1; fs = 5'h1E; s = 32'd6; t = 32'd7; shamt = '0;
    @(negedge clk);
    start = 1'b0; s = '1; t = '1;
    dones = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dones++;
        done_at = k;
      end
      if (k == 5 || k == 32) begin
        start = 1'b1; fs = 5'h02; s = 32'd1; t = 32'd1;
      end
    end
    check("mid/dones",  64'(dones), 64'd1);
    check("mid/at",     64'(done_at), 64'd33);
    check("mid/y",      {y_hi, y_lo}, {32'h0, 32'h2A});
    check("mid/flags",  64'({c, v, n, z, dz}), 64'd0);

    // reset during DIV iteration 10 aborts without a done
    start = 1'b1; fs = 5'h1F; s = 32'd100; t = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort/y",   {y_hi, y_lo}, 64'd0);
    check("abort/ctl", 64'({busy, done, c, v, n, z, dz}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_seen++;
    end
    check("abort/nodone", 64'(dones), 64'd0);
    check("abort/nobusy", 64'(busy_seen), 64'd0);
    op32("post_add", 5'h02, 32'h1, 32'h2, 5'd0, 0, 32'h0, 32'h3, 5'b00000);

    // W=16 MUL/DIV against reference arithmetic, including corner operands
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) rb = 16'h0;
      if (i == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
      if (i == 2) begin ra = 16'h8000; rb = 16'h8000; end
      ea = {{16{ra[15]}}, ra};
      eb = {{16{rb[15]}}, rb};
      ep = ea * eb;
      mh = ep[31:16];
      ml = ep[15:0];
      mf = {1'b0, 1'b0, mh[15], (ep == 0), 1'b0};
      if (rb == 16'h0) begin
        dh = ra; dl = 16'hFFFF;
        df = 5'b00101;
      end else if (ra == 16'h8000 && rb == 16'hFFFF) begin
        dh = 16'h0; dl = 16'h8000;
        df = 5'b01100;
      end else begin
        qa = ra; qb = rb;
        qq = qa / qb;
        qr = qa % qb;
        dh = qr; dl = qq;
        df = {1'b0, 1'b0, dl[15], ({dh, dl} == 32'h0), 1'b0};
      end
      op16($sformatf("mul16_%0d", i), 5'h1E, ra, rb, mh, ml, mf);
      op16($sformatf("div16_%0d", i), 5'h1F, ra, rb, dh, dl, df);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
